// File: rtl/alarm_datapath.sv
// alarm_datapath: time/alarm registers, edit buffer, alarm match and ring/snooze sequencer
module alarm_datapath #(
  parameter int MAX_SNZ = 3,
  parameter int DAYS = 7
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tick_Min,
  input  logic       ID,
  input  logic       IH,
  input  logic       IM,
  input  logic       LD_TIME,
  input  logic       LD_R,
  input  logic       TOF,
  input  logic       Snooze,
  input  logic       Stop,
  input  logic       Snz_Done,
  input  logic       Stop_Done,
  output logic       EN_SNZ,
  output logic       EN_STOP,
  output logic       Alarm,
  output logic       Alarm_On,
  output logic [2:0] T_Day,
  output logic [4:0] T_Hour,
  output logic [5:0] T_Min,
  output logic [2:0] E_Day,
  output logic [4:0] E_Hour,
  output logic [5:0] E_Min,
  output logic [2:0] A_Day,
  output logic [4:0] A_Hour,
  output logic [5:0] A_Min
);
  localparam int CW = $clog2(MAX_SNZ + 1);
  localparam logic [2:0] DMAX = 3'(DAYS - 1);
  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic r_chg;
  logic w_match, w_off, w_mwrap, w_hwrap;
  // match only on the cycle after the time registers moved, so loading the alarm onto "now" stays silent
  assign w_match = r_chg & Alarm_On & (T_Day == A_Day) & (T_Hour == A_Hour) & (T_Min == A_Min);
  assign w_off = TOF & Alarm_On;
  assign w_mwrap = T_Min == 6'd59;
  assign w_hwrap = T_Hour == 5'd23;
  always_comb begin
    w_next = w_off ? IDLE :
             r_state == IDLE ? (w_match ? RING : IDLE) :
             r_state == RING ? ((Stop | Stop_Done) ? IDLE :
                                (Snooze && r_cnt < CW'(MAX_SNZ)) ? SNOOZE : RING) :
             Stop ? IDLE : Snz_Done ? RING : SNOOZE;
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      {T_Day, T_Hour, T_Min} <= '0;
      {E_Day, E_Hour, E_Min} <= '0;
      {A_Day, A_Hour, A_Min} <= '0;
      Alarm_On <= 1'b0;
      r_chg <= 1'b0;
      r_state <= IDLE;
      r_cnt <= '0;
      {EN_SNZ, EN_STOP, Alarm} <= '0;
    end else begin
      if (IM) E_Min <= (E_Min == 6'd59) ? 6'd0 : E_Min + 6'd1;
      if (IH) E_Hour <= (E_Hour == 5'd23) ? 5'd0 : E_Hour + 5'd1;
      if (ID) E_Day <= (E_Day == DMAX) ? 3'd0 : E_Day + 3'd1;
      if (LD_TIME) begin
        {T_Day, T_Hour, T_Min} <= {E_Day, E_Hour, E_Min};
      end else if (Tick_Min) begin
        T_Min <= w_mwrap ? 6'd0 : T_Min + 6'd1;
        if (w_mwrap) T_Hour <= w_hwrap ? 5'd0 : T_Hour + 5'd1;
        if (w_mwrap && w_hwrap) T_Day <= (T_Day == DMAX) ? 3'd0 : T_Day + 3'd1;
      end
      r_chg <= LD_TIME | Tick_Min;
      if (LD_R) {A_Day, A_Hour, A_Min} <= {E_Day, E_Hour, E_Min};
      if (TOF) Alarm_On <= ~Alarm_On;
      r_state <= w_next;
      if (r_state == IDLE && w_next == RING) r_cnt <= '0;
      else if (r_state == RING && w_next == SNOOZE) r_cnt <= r_cnt + 1'b1;
      Alarm <= w_next == RING;
      EN_STOP <= w_next == RING;
      EN_SNZ <= w_next == SNOOZE;
    end
  end
endmodule

// File: tb/tb_alarm_datapath.sv
// tb_alarm_datapath: directed test-plan sequences plus random strobes against a minute-of-week reference model
module tb_alarm_datapath;
  localparam int MAX_SNZ = 3;
  localparam int DAYS = 7;
  localparam int WEEK = DAYS * 1440;
  logic Clk = 1'b0;
  logic Rst = 1'b0, Tick_Min = 1'b0, ID = 1'b0, IH = 1'b0, IM = 1'b0, LD_TIME = 1'b0, LD_R = 1'b0;
  logic TOF = 1'b0, Snooze = 1'b0, Stop = 1'b0, Snz_Done = 1'b0, Stop_Done = 1'b0;
  logic EN_SNZ, EN_STOP, Alarm, Alarm_On;
  logic [2:0] T_Day, E_Day, A_Day;
  logic [4:0] T_Hour, E_Hour, A_Hour;
  logic [5:0] T_Min, E_Min, A_Min;
  int checks = 0, errors = 0;
  int me_d, me_h, me_m, mt, ma, m_on, m_chg, m_mode, m_cnt;
  alarm_datapath #(.MAX_SNZ(MAX_SNZ), .DAYS(DAYS)) dut (
    .Clk(Clk), .Rst(Rst), .Tick_Min(Tick_Min), .ID(ID), .IH(IH), .IM(IM),
    .LD_TIME(LD_TIME), .LD_R(LD_R), .TOF(TOF), .Snooze(Snooze), .Stop(Stop),
    .Snz_Done(Snz_Done), .Stop_Done(Stop_Done), .EN_SNZ(EN_SNZ), .EN_STOP(EN_STOP),
    .Alarm(Alarm), .Alarm_On(Alarm_On), .T_Day(T_Day), .T_Hour(T_Hour), .T_Min(T_Min),
    .E_Day(E_Day), .E_Hour(E_Hour), .E_Min(E_Min), .A_Day(A_Day), .A_Hour(A_Hour), .A_Min(A_Min)
  );
  always #5 Clk = ~Clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [15:0] pack(input int d, input int h, input int m);
    return {2'b00, d[2:0], h[4:0], m[5:0]};
  endfunction
  function automatic logic [15:0] pack_w(input int w);
    return pack(w / 1440, (w % 1440) / 60, w % 60);
  endfunction
  // mode: 0 idle, 1 ringing, 2 snoozing; time and alarm kept as minute-of-week
  task automatic model_step();
    bit match;
    int e_w;
    if (Rst) begin
      {me_d, me_h, me_m, mt, ma, m_on, m_chg, m_mode, m_cnt} = '0;
      return;
    end
    match = m_chg != 0 && m_on != 0 && mt == ma;
    e_w = me_d * 1440 + me_h * 60 + me_m;
    if (TOF && m_on != 0) m_mode = 0;
    else if (m_mode == 0) begin
      if (match) begin m_mode = 1; m_cnt = 0; end
    end else if (m_mode == 1) begin
      if (Stop || Stop_Done) m_mode = 0;
      else if (Snooze && m_cnt < MAX_SNZ) begin m_mode = 2; m_cnt++; end
    end else begin
      if (Stop) m_mode = 0;
      else if (Snz_Done) m_mode = 1;
    end
    m_chg = (LD_TIME || Tick_Min) ? 1 : 0;
    mt = LD_TIME ? e_w : Tick_Min ? (mt + 1) % WEEK : mt;
    if (LD_R) ma = e_w;
    if (TOF) m_on = 1 - m_on;
    if (ID) me_d = (me_d + 1) % DAYS;
    if (IH) me_h = (me_h + 1) % 24;
    if (IM) me_m = (me_m + 1) % 60;
  endtask
  task automatic verify();
    check("E", pack(E_Day, E_Hour, E_Min), pack(me_d, me_h, me_m));
    check("T", pack(T_Day, T_Hour, T_Min), pack_w(mt));
    check("A", pack(A_Day, A_Hour, A_Min), pack_w(ma));
    check("ALARM_ON", 16'(Alarm_On), 16'(m_on));
    check("ALARM", 16'(Alarm), 16'(m_mode == 1));
    check("EN_STOP", 16'(EN_STOP), 16'(m_mode == 1));
    check("EN_SNZ", 16'(EN_SNZ), 16'(m_mode == 2));
  endtask
  task automatic cyc();
    model_step();
    @(posedge Clk);
    #1;
    verify();
    {Rst, Tick_Min, ID, IH, IM, LD_TIME, LD_R, TOF, Snooze, Stop, Snz_Done, Stop_Done} = '0;
  endtask
  task automatic outs(input string tag, input logic [2:0] exp);
    check(tag, {13'd0, Alarm, EN_STOP, EN_SNZ}, {13'd0, exp});
  endtask
  initial begin
    Rst = 1; cyc();
    check("rst_T", pack(T_Day, T_Hour, T_Min), 16'd0);
    outs("rst_outs", 3'b000);
    repeat (3) begin IM = 1; cyc(); end
    repeat (2) begin IH = 1; cyc(); end
    ID = 1; cyc();
    LD_TIME = 1; cyc();
    check("tp1_T", pack(T_Day, T_Hour, T_Min), pack(1, 2, 3));
    check("tp1_E", pack(E_Day, E_Hour, E_Min), pack(1, 2, 3));
    for (int i = 0; i < 56; i++) begin IM = 1; IH = i < 21; ID = i < 5; cyc(); end
    LD_TIME = 1; cyc();
    check("tp2_load", pack(T_Day, T_Hour, T_Min), pack(6, 23, 59));
    Tick_Min = 1; cyc();
    check("tp2_wrap", pack(T_Day, T_Hour, T_Min), 16'd0);
    Rst = 1; cyc();
    for (int i = 0; i < 30; i++) begin IM = 1; IH = i < 6; ID = i < 2; cyc(); end
    LD_R = 1; cyc();
    TOF = 1; cyc();
    repeat (59) begin IM = 1; cyc(); end
    LD_TIME = 1; cyc();
    Tick_Min = 1; cyc();
    outs("tp3_tick1", 3'b000);
    cyc();
    outs("tp3_ring", 3'b110);
    Stop = 1; cyc();
    outs("tp3_stop", 3'b000);
    LD_TIME = 1; cyc();
    Tick_Min = 1; cyc();
    cyc();
    outs("tp4_ring", 3'b110);
    for (int k = 0; k < MAX_SNZ; k++) begin
      Snooze = 1; cyc();
      outs("tp4_snz", 3'b001);
      Snz_Done = 1; cyc();
      outs("tp4_back", 3'b110);
    end
    Snooze = 1; cyc();
    outs("tp4_snz_ignored", 3'b110);
    Stop_Done = 1; cyc();
    outs("tp4_timeout", 3'b000);
    Rst = 1; cyc();
    repeat (10) begin IH = 1; cyc(); end
    LD_TIME = 1; Tick_Min = 1; cyc();
    check("tp5_ld_beats_tick", pack(T_Day, T_Hour, T_Min), pack(0, 10, 0));
    LD_R = 1; TOF = 1; cyc();
    LD_TIME = 1; cyc();
    cyc();
    outs("tp5_ring", 3'b110);
    Snooze = 1; cyc();
    Stop = 1; Snz_Done = 1; cyc();
    outs("tp5_stop_wins", 3'b000);
    LD_TIME = 1; cyc();
    cyc();
    Snooze = 1; cyc();
    TOF = 1; cyc();
    check("tp6_off", 16'(Alarm_On), 16'd0);
    outs("tp6_idle", 3'b000);
    TOF = 1; cyc();
    LD_TIME = 1; cyc();
    cyc();
    outs("tp6_ring", 3'b110);
    Rst = 1; cyc();
    outs("tp6_rst", 3'b000);
    check("tp6_rst_regs", {15'd0, Alarm_On} | pack(T_Day, T_Hour, T_Min) | pack(A_Day, A_Hour, A_Min), 16'd0);
    for (int i = 0; i < 3000; i++) begin
      Rst = $urandom_range(0, 999) < 3;
      Tick_Min = $urandom_range(0, 99) < 30;
      ID = $urandom_range(0, 99) < 10;
      IH = $urandom_range(0, 99) < 10;
      IM = $urandom_range(0, 99) < 10;
      LD_TIME = $urandom_range(0, 99) < 4;
      LD_R = $urandom_range(0, 99) < 4;
      TOF = $urandom_range(0, 99) < 3;
      Snooze = $urandom_range(0, 99) < 15;
      Stop = $urandom_range(0, 99) < 3;
      Snz_Done = $urandom_range(0, 99) < 15;
      Stop_Done = $urandom_range(0, 99) < 3;
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
